// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the instruction/data SRAM arbiter.
package memory_arbiter_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/memory_arbiter_wait_counter.sv
// Wait-state down-counter: load, decrement towards zero, zero flag.
module wait_counter
    import memory_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the IF and MEM stages.
// Each access occupies IDLE-grant, WAIT_CYCLES of ACCESS, then one DONE/ack cycle.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    state_t            state;
    state_t            state_next;
    owner_t            grant;
    owner_t            owner_q;
    owner_t            last_owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    // Tie goes to whichever side did not own the previous access.
    always_comb begin
        grant = OWN_I;
        if (i_req && d_req) begin
            grant = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            grant = OWN_D;
        end
    end

    assign cnt_load = (state == IDLE) && (i_req || d_req);
    assign cnt_dec  = (state == ACCESS);

    wait_counter u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(WAIT_CYCLES - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_req || d_req) state_next = ACCESS;
            ACCESS:  if (cnt_zero) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= OWN_I;
            last_owner <= OWN_I;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (cnt_load) begin
                owner_q <= grant;
                we_q    <= (grant == OWN_D) ? d_we : 1'b0;
                addr_q  <= (grant == OWN_D) ? d_addr : i_addr;
                wdata_q <= (grant == OWN_D) ? d_wdata : '0;
            end
            if ((state == ACCESS) && cnt_zero && !we_q) begin
                if (owner_q == OWN_D) begin
                    d_rdata_q <= sram_rdata;
                end else begin
                    i_rdata_q <= sram_rdata;
                end
            end
            if (state == DONE) begin
                last_owner <= owner_q;
            end
        end
    end

    // Outputs decode the state register so an async reset clears them at once.
    always_comb begin
        sram_en    = (state == ACCESS);
        sram_we    = (state == ACCESS) && we_q;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        i_ack      = (state == DONE) && (owner_q == OWN_I);
        d_ack      = (state == DONE) && (owner_q == OWN_D);
        i_rdata    = i_rdata_q;
        d_rdata    = d_rdata_q;
        i_stall    = i_req && !i_ack;
        d_stall    = d_req && !d_ack;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed-vector bench for memory_arbiter with WAIT_CYCLES = 4 and a small SRAM model.
module tb_memory_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [15:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_stall;
    logic        sram_en;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks;
    int errors;

    logic [31:0] mem [0:1023];

    memory_arbiter #(
        .WAIT_CYCLES (4),
        .ADDR_W      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ack      (i_ack),
        .i_stall    (i_stall),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ack      (d_ack),
        .d_stall    (d_stall),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word 0x0010 is preloaded with an instruction; everything else comes from writes.
    assign sram_rdata = (sram_addr == 16'h0010) ? 32'hE3A01005 : mem[sram_addr[9:0]];

    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr[9:0]] <= sram_wdata;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sram_en, sram_we, i_ack, d_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {sram_en, sram_we, i_ack, d_ack});
        end
        checks++;
        if ({sram_addr, sram_wdata} !== 48'h0) begin
            errors++;
            $display("FAIL reset_sram_bus: got %h expected 0", {sram_addr, sram_wdata});
        end
        checks++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata});
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_instr_read();
        i_req  = 1'b1;
        i_addr = 16'h0010;
        for (int cyc = 0; cyc <= 7; cyc++) begin
            if (cyc == 6) i_req = 1'b0;
            @(negedge clk);
            checks++;
            if (sram_en !== (cyc >= 1 && cyc <= 4)) begin
                errors++;
                $display("FAIL ird_sram_en c%0d: got %b expected %b", cyc, sram_en, (cyc >= 1 && cyc <= 4));
            end
            checks++;
            if (i_ack !== (cyc == 5)) begin
                errors++;
                $display("FAIL ird_i_ack c%0d: got %b expected %b", cyc, i_ack, (cyc == 5));
            end
            checks++;
            if (i_stall !== (cyc <= 4)) begin
                errors++;
                $display("FAIL ird_i_stall c%0d: got %b expected %b", cyc, i_stall, (cyc <= 4));
            end
            if (cyc == 1) begin
                checks++;
                if (sram_addr !== 16'h0010 || sram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL ird_addr: got addr %h we %b expected addr 0010 we 0", sram_addr, sram_we);
                end
            end
            if (cyc == 5) begin
                checks++;
                if (i_rdata !== 32'hE3A01005) begin
                    errors++;
                    $display("FAIL ird_rdata: got %h expected e3a01005", i_rdata);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_data_write();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0100;
        d_wdata = 32'hDEADBEEF;
        for (int cyc = 0; cyc <= 6; cyc++) begin
            if (cyc == 6) d_req = 1'b0;
            @(negedge clk);
            checks++;
            if (sram_we !== (cyc >= 1 && cyc <= 4)) begin
                errors++;
                $display("FAIL wr_sram_we c%0d: got %b expected %b", cyc, sram_we, (cyc >= 1 && cyc <= 4));
            end
            checks++;
            if (d_ack !== (cyc == 5)) begin
                errors++;
                $display("FAIL wr_d_ack c%0d: got %b expected %b", cyc, d_ack, (cyc == 5));
            end
            checks++;
            if (d_stall !== (cyc <= 4)) begin
                errors++;
                $display("FAIL wr_d_stall c%0d: got %b expected %b", cyc, d_stall, (cyc <= 4));
            end
            if (cyc == 2) begin
                checks++;
                if (sram_addr !== 16'h0100 || sram_wdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL wr_bus: got %h/%h expected 0100/deadbeef", sram_addr, sram_wdata);
                end
            end
            if (cyc == 5) begin
                checks++;
                if (d_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL wr_rdata_untouched: got %h expected 0", d_rdata);
                end
            end
            @(posedge clk);
            #1;
        end
        d_req = 1'b1;
        d_we  = 1'b0;
        for (int cyc = 0; cyc <= 6; cyc++) begin
            if (cyc == 6) d_req = 1'b0;
            @(negedge clk);
            checks++;
            if (sram_we !== 1'b0) begin
                errors++;
                $display("FAIL rd_sram_we c%0d: got %b expected 0", cyc, sram_we);
            end
            checks++;
            if (d_ack !== (cyc == 5)) begin
                errors++;
                $display("FAIL rd_d_ack c%0d: got %b expected %b", cyc, d_ack, (cyc == 5));
            end
            if (cyc == 5) begin
                checks++;
                if (d_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL rd_readback: got %h expected deadbeef", d_rdata);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rdata_hold();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0104;
        d_wdata = 32'h0BADF00D;
        for (int cyc = 0; cyc <= 6; cyc++) begin
            if (cyc == 6) d_req = 1'b0;
            @(negedge clk);
            if (cyc == 5) begin
                checks++;
                if (d_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_d_ack: got %b expected 1", d_ack);
                end
                checks++;
                if (d_rdata !== 32'hDEADBEEF || i_rdata !== 32'hE3A01005) begin
                    errors++;
                    $display("FAIL hold_rdata: got %h/%h expected deadbeef/e3a01005", d_rdata, i_rdata);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_tie_round_robin();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        i_req  = 1'b1;
        i_addr = 16'h0010;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0100;
        for (int cyc = 0; cyc <= 17; cyc++) begin
            if (cyc == 6) d_req = 1'b0;
            if (cyc == 12) begin
                d_req  = 1'b1;
                d_addr = 16'h0104;
            end
            @(negedge clk);
            checks++;
            if (d_ack !== (cyc == 5 || cyc == 17)) begin
                errors++;
                $display("FAIL tie_d_ack c%0d: got %b expected %b", cyc, d_ack, (cyc == 5 || cyc == 17));
            end
            checks++;
            if (i_ack !== (cyc == 11)) begin
                errors++;
                $display("FAIL tie_i_ack c%0d: got %b expected %b", cyc, i_ack, (cyc == 11));
            end
            checks++;
            if (sram_en !== ((cyc >= 1 && cyc <= 4) || (cyc >= 7 && cyc <= 10) || (cyc >= 13 && cyc <= 16))) begin
                errors++;
                $display("FAIL tie_sram_en c%0d: got %b", cyc, sram_en);
            end
            if (cyc == 1 || cyc == 7 || cyc == 13) begin
                checks++;
                if (sram_addr !== ((cyc == 1) ? 16'h0100 : (cyc == 7) ? 16'h0010 : 16'h0104)) begin
                    errors++;
                    $display("FAIL tie_addr c%0d: got %h expected %h", cyc, sram_addr,
                             ((cyc == 1) ? 16'h0100 : (cyc == 7) ? 16'h0010 : 16'h0104));
                end
            end
            if (cyc == 5 || cyc == 17) begin
                checks++;
                if (d_rdata !== ((cyc == 5) ? 32'hDEADBEEF : 32'h0BADF00D)) begin
                    errors++;
                    $display("FAIL tie_d_rdata c%0d: got %h expected %h", cyc, d_rdata,
                             ((cyc == 5) ? 32'hDEADBEEF : 32'h0BADF00D));
                end
            end
            if (cyc == 11) begin
                checks++;
                if (i_rdata !== 32'hE3A01005) begin
                    errors++;
                    $display("FAIL tie_i_rdata: got %h expected e3a01005", i_rdata);
                end
            end
            @(posedge clk);
            #1;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        i_req  = 1'b1;
        i_addr = 16'h0010;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            if (cyc == 2) i_req = 1'b0;
            @(negedge clk);
            checks++;
            if (i_ack !== (cyc == 5)) begin
                errors++;
                $display("FAIL flush_i_ack c%0d: got %b expected %b", cyc, i_ack, (cyc == 5));
            end
            checks++;
            if (sram_en !== (cyc >= 1 && cyc <= 4)) begin
                errors++;
                $display("FAIL flush_sram_en c%0d: got %b expected %b", cyc, sram_en, (cyc >= 1 && cyc <= 4));
            end
            checks++;
            if (i_stall !== (cyc <= 1)) begin
                errors++;
                $display("FAIL flush_i_stall c%0d: got %b expected %b", cyc, i_stall, (cyc <= 1));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_write();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0200;
        d_wdata = 32'h12345678;
        for (int cyc = 0; cyc <= 2; cyc++) begin
            @(negedge clk);
            checks++;
            if (sram_we !== (cyc >= 1)) begin
                errors++;
                $display("FAIL mid_sram_we c%0d: got %b expected %b", cyc, sram_we, (cyc >= 1));
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({sram_en, sram_we, d_ack} !== 3'b000) begin
            errors++;
            $display("FAIL mid_async_drop: got %b expected 000", {sram_en, sram_we, d_ack});
        end
        checks++;
        if (d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_rdata_clear: got %h expected 0", d_rdata);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        d_req = 1'b0;
        for (int cyc = 0; cyc <= 5; cyc++) begin
            @(negedge clk);
            checks++;
            if ({sram_en, d_ack} !== 2'b00) begin
                errors++;
                $display("FAIL mid_quiet c%0d: got %b expected 00", cyc, {sram_en, d_ack});
            end
            @(posedge clk);
            #1;
        end
        d_req   = 1'b1;
        d_wdata = 32'hCAFEF00D;
        for (int cyc = 0; cyc <= 6; cyc++) begin
            if (cyc == 6) d_req = 1'b0;
            @(negedge clk);
            checks++;
            if (d_ack !== (cyc == 5)) begin
                errors++;
                $display("FAIL mid_rewrite_ack c%0d: got %b expected %b", cyc, d_ack, (cyc == 5));
            end
            @(posedge clk);
            #1;
        end
        d_req = 1'b1;
        d_we  = 1'b0;
        for (int cyc = 0; cyc <= 6; cyc++) begin
            if (cyc == 6) d_req = 1'b0;
            @(negedge clk);
            if (cyc == 5) begin
                checks++;
                if (d_ack !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin
                    errors++;
                    $display("FAIL mid_readback: got ack %b data %h expected ack 1 data cafef00d", d_ack, d_rdata);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        test_reset();
        test_instr_read();
        test_data_write();
        test_rdata_hold();
        test_tie_round_robin();
        test_flush();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
